acc_ctrl_fsm: RTL and testbench

- Multi-cycle sequential control unit for the accumulator datapath (AC, PC, MA, MD, IR, carry).
- Successor to the single-cycle combinational decoder.
- Sequences fetch, optional indirect address, execute and memory access over a req/ack memory handshake.
- Adds start/halt, a retired-instruction counter and an optional memory-timeout error, and drives the same datapath enables and mux selects.

---
 rtl/acc_ctrl_pkg.sv | 42 ++++
 rtl/acc_ctrl_fsm_if.sv | 36 +++
 rtl/acc_ctrl_mem_timer.sv | 29 ++
 rtl/acc_ctrl_fsm.sv | 174 +++++++++++++++++
 tb/tb_acc_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator control sequencer:
// opcodes, sequencer states and datapath mux selects.
package acc_ctrl_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_JPA  = 3'b010;
    localparam logic [2:0] OP_INCA = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    typedef enum logic [3:0] {
        IDLE,
        F_ADDR,
        F_MEM,
        DECODE,
        I_ADDR,
        I_MEM,
        I_JMP,
        E_ADDR,
        E_MEM,
        E_ALU,
        HALT
    } state_t;

    // MA source select
    localparam logic [1:0] MA_PC = 2'd0;
    localparam logic [1:0] MA_IR = 2'd1;
    localparam logic [1:0] MA_MD = 2'd2;

    // PC source select
    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_IR  = 2'd1;
    localparam logic [1:0] PC_MD  = 2'd2;

    function automatic logic is_mem_state(input state_t s);
        return s inside {F_MEM, I_MEM, E_MEM};
    endfunction

endpackage

// File: rtl/acc_ctrl_fsm_if.sv
// Datapath-facing bundle: IR/status inputs to the sequencer, and the
// register enables, mux selects and memory handshake it drives.
interface acc_ctrl_fsm_if #(
    parameter int ALU_W = 3
);
    logic [2:0]       ir_op;
    logic             ir_ind;
    logic             pos;
    logic             mem_ack;
    logic [1:0]       mux1c;
    logic [1:0]       mux2c;
    logic             mux3c;
    logic [ALU_W-1:0] alu_c;
    logic             en_ir;
    logic             en_md;
    logic             en_ac;
    logic             en_pc;
    logic             en_ma;
    logic             en_c;
    logic             mem_rd;
    logic             mem_wr;

    modport master (
        input  ir_op, ir_ind, pos, mem_ack,
        output mux1c, mux2c, mux3c, alu_c,
        output en_ir, en_md, en_ac, en_pc, en_ma, en_c,
        output mem_rd, mem_wr
    );

    modport slave (
        output ir_op, ir_ind, pos, mem_ack,
        input  mux1c, mux2c, mux3c, alu_c,
        input  en_ir, en_md, en_ac, en_pc, en_ma, en_c,
        input  mem_rd, mem_wr
    );
endinterface

// File: rtl/acc_ctrl_mem_timer.sv
// Wait-cycle counter for a memory state; expire_o flags the cycle in which
// the MEM_TIMEOUT-th consecutive cycle without ack is being spent.
module acc_ctrl_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/acc_ctrl_fsm.sv
// Multi-cycle sequencer for the accumulator datapath: fetch, optional
// indirect address, execute and memory access over a req/ack handshake.
module acc_ctrl_fsm
    import acc_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int          ALU_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    acc_ctrl_fsm_if.master       dp,
    output logic                 retire,
    output logic [CNT_W-1:0]     instr_cnt,
    output logic                 halted,
    output logic                 err
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             halted_q;
    logic             expire;
    logic             timeout;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            // Every memory state is entered from a non-memory state, so
            // clearing outside them gives a fresh count on each entry.
            acc_ctrl_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr_i    (!is_mem_state(state_q)),
                .inc_i    (is_mem_state(state_q) && !dp.mem_ack),
                .expire_o (expire)
            );
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            // NOTE: all state updates use <= so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_q + CNT_W'(retire);
            err_q    <= err_q | timeout;
            halted_q <= (state_d == HALT);
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through it can infer a latch.
        state_d     = state_q;
        dp.mux1c    = MA_PC;
        dp.mux2c    = PC_INC;
        dp.mux3c    = 1'b0;
        dp.alu_c    = '0;
        dp.en_ir    = 1'b0;
        dp.en_md    = 1'b0;
        dp.en_ac    = 1'b0;
        dp.en_pc    = 1'b0;
        dp.en_ma    = 1'b0;
        dp.en_c     = 1'b0;
        dp.mem_rd   = 1'b0;
        dp.mem_wr   = 1'b0;
        retire      = 1'b0;
        timeout     = 1'b0;

        unique case (state_q)
            IDLE: if (start) state_d = F_ADDR;
            F_ADDR: begin
                dp.en_ma = 1'b1;
                dp.mux1c = MA_PC;
                state_d  = F_MEM;
            end
            F_MEM: begin
                dp.mem_rd = 1'b1;
                if (dp.mem_ack) begin
                    dp.en_ir = 1'b1;
                    dp.en_pc = 1'b1;
                    dp.mux2c = PC_INC;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                case (dp.ir_op)
                    OP_NOT, OP_INCA: state_d = E_ALU;
                    OP_NOP: begin
                        state_d = F_ADDR;
                        retire  = 1'b1;
                    end
                    OP_HLT: begin
                        state_d = HALT;
                        retire  = 1'b1;
                    end
                    OP_JPA: begin
                        if (dp.pos && dp.ir_ind) begin
                            state_d = I_ADDR;
                        end else begin
                            dp.en_pc = dp.pos;
                            dp.mux2c = dp.pos ? PC_IR : PC_INC;
                            state_d  = F_ADDR;
                            retire   = 1'b1;
                        end
                    end
                    default: state_d = dp.ir_ind ? I_ADDR : E_ADDR;
                endcase
            end
            I_ADDR: begin
                dp.en_ma = 1'b1;
                dp.mux1c = MA_IR;
                state_d  = I_MEM;
            end
            I_MEM: begin
                dp.mem_rd = 1'b1;
                dp.en_md  = dp.mem_ack;
                if (dp.mem_ack) state_d = (dp.ir_op == OP_JPA) ? I_JMP : E_ADDR;
            end
            I_JMP: begin
                dp.en_pc = 1'b1;
                dp.mux2c = PC_MD;
                state_d  = F_ADDR;
                retire   = 1'b1;
            end
            E_ADDR: begin
                dp.en_ma = 1'b1;
                dp.mux1c = dp.ir_ind ? MA_MD : MA_IR;
                state_d  = E_MEM;
            end
            E_MEM: begin
                if (dp.ir_op == OP_STA) begin
                    dp.mem_wr = 1'b1;
                    dp.mux3c  = 1'b1;
                    if (dp.mem_ack) begin
                        state_d = F_ADDR;
                        retire  = 1'b1;
                    end
                end else begin
                    dp.mem_rd = 1'b1;
                    dp.en_md  = dp.mem_ack;
                    if (dp.mem_ack) state_d = E_ALU;
                end
            end
            E_ALU: begin
                dp.en_ac = 1'b1;
                dp.alu_c = ALU_W'(dp.ir_op);
                dp.en_c  = (dp.ir_op == OP_ADC);
                state_d  = F_ADDR;
                retire   = 1'b1;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase

        // An ack in the expiry cycle has already completed the access above.
        if (expire && is_mem_state(state_q) && !dp.mem_ack) begin
            state_d = HALT;
            timeout = 1'b1;
        end
    end

    assign instr_cnt = cnt_q;
    assign err       = err_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm with CNT_W=2 and MEM_TIMEOUT=4; control
// outputs are packed into one vector and compared against hand-built codes.
module tb_acc_ctrl_fsm;
    localparam int CNT_W = 2;

    // Bit positions of the packed control vector ctl[16:0]
    localparam logic [16:0] B_RT  = 17'h00001;
    localparam logic [16:0] B_WR  = 17'h00002;
    localparam logic [16:0] B_RD  = 17'h00004;
    localparam logic [16:0] B_C   = 17'h00008;
    localparam logic [16:0] B_MA  = 17'h00010;
    localparam logic [16:0] B_PC  = 17'h00020;
    localparam logic [16:0] B_AC  = 17'h00040;
    localparam logic [16:0] B_MD  = 17'h00080;
    localparam logic [16:0] B_IR  = 17'h00100;
    localparam logic [16:0] B_M3  = 17'h01000;
    localparam logic [16:0] M2_IR = 17'h02000;
    localparam logic [16:0] M2_MD = 17'h04000;
    localparam logic [16:0] M1_IR = 17'h08000;
    localparam logic [16:0] M1_MD = 17'h10000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             retire;
    logic [CNT_W-1:0] instr_cnt;
    logic             halted;
    logic             err;
    logic [16:0]      ctl;
    int               checks = 0;
    int               errors = 0;

    acc_ctrl_fsm_if #(.ALU_W(3)) dp ();

    acc_ctrl_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .ALU_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dp        (dp),
        .retire    (retire),
        .instr_cnt (instr_cnt),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign ctl = {dp.mux1c, dp.mux2c, dp.mux3c, dp.alu_c, dp.en_ir, dp.en_md,
                  dp.en_ac, dp.en_pc, dp.en_ma, dp.en_c, dp.mem_rd, dp.mem_wr, retire};

    function automatic logic [16:0] alu(input logic [2:0] op);
        return {5'b0, op, 9'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the control vector mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [16:0] exp);
        @(negedge clk);
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0;
        dp.ir_op = 3'b000; dp.ir_ind = 1'b0; dp.pos = 1'b0; dp.mem_ack = 1'b0;
        #7;
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        chk("rst_halted_err", {30'b0, halted, err}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // LDA direct, two wait cycles on each access
        dp.ir_op = 3'b101; start = 1'b1;
        cyc("lda_idle", 17'h0); start = 1'b0;
        cyc("lda_faddr", B_MA);
        cyc("lda_fmem_w1", B_RD);
        cyc("lda_fmem_w2", B_RD);
        dp.mem_ack = 1'b1;
        cyc("lda_fmem_ack", B_RD | B_IR | B_PC);
        dp.mem_ack = 1'b0;
        cyc("lda_decode", 17'h0);
        cyc("lda_eaddr", B_MA | M1_IR);
        cyc("lda_emem_w1", B_RD);
        cyc("lda_emem_w2", B_RD);
        dp.mem_ack = 1'b1;
        cyc("lda_emem_ack", B_RD | B_MD);
        dp.mem_ack = 1'b0;
        cyc("lda_ealu", B_AC | alu(3'b101) | B_RT);
        chk("lda_cnt", 32'(instr_cnt), 32'd1);

        // ADC indirect, ack held high (ignored outside memory states)
        dp.ir_op = 3'b001; dp.ir_ind = 1'b1; dp.mem_ack = 1'b1;
        cyc("adc_faddr", B_MA);
        cyc("adc_fmem", B_RD | B_IR | B_PC);
        cyc("adc_decode", 17'h0);
        cyc("adc_iaddr", B_MA | M1_IR);
        cyc("adc_imem", B_RD | B_MD);
        cyc("adc_eaddr", B_MA | M1_MD);
        cyc("adc_emem", B_RD | B_MD);
        cyc("adc_ealu", B_AC | alu(3'b001) | B_C | B_RT);
        chk("adc_cnt", 32'(instr_cnt), 32'd2);

        // JPA direct, pos=0 then pos=1; then indirect with pos=1
        dp.ir_op = 3'b010; dp.ir_ind = 1'b0; dp.pos = 1'b0;
        cyc("jpa0_faddr", B_MA);
        cyc("jpa0_fmem", B_RD | B_IR | B_PC);
        cyc("jpa0_decode", B_RT);
        chk("jpa0_cnt", 32'(instr_cnt), 32'd3);
        dp.pos = 1'b1;
        cyc("jpa1_faddr", B_MA);
        cyc("jpa1_fmem", B_RD | B_IR | B_PC);
        cyc("jpa1_decode", B_PC | M2_IR | B_RT);
        chk("jpa1_cnt_wrap", 32'(instr_cnt), 32'd0);
        dp.ir_ind = 1'b1;
        cyc("jpai_faddr", B_MA);
        cyc("jpai_fmem", B_RD | B_IR | B_PC);
        cyc("jpai_decode", 17'h0);
        cyc("jpai_iaddr", B_MA | M1_IR);
        cyc("jpai_imem", B_RD | B_MD);
        cyc("jpai_ijmp", B_PC | M2_MD | B_RT);
        chk("jpai_cnt", 32'(instr_cnt), 32'd1);

        // STA direct, one wait cycle on the write
        dp.ir_op = 3'b100; dp.ir_ind = 1'b0; dp.pos = 1'b0;
        cyc("sta_faddr", B_MA);
        cyc("sta_fmem", B_RD | B_IR | B_PC);
        cyc("sta_decode", 17'h0);
        cyc("sta_eaddr", B_MA | M1_IR);
        dp.mem_ack = 1'b0;
        cyc("sta_emem_w1", B_WR | B_M3);
        dp.mem_ack = 1'b1;
        cyc("sta_emem_ack", B_WR | B_M3 | B_RT);
        chk("sta_cnt", 32'(instr_cnt), 32'd2);

        // INCA
        dp.ir_op = 3'b011;
        cyc("inca_faddr", B_MA);
        cyc("inca_fmem", B_RD | B_IR | B_PC);
        cyc("inca_decode", 17'h0);
        cyc("inca_ealu", B_AC | alu(3'b011) | B_RT);
        chk("inca_cnt", 32'(instr_cnt), 32'd3);

        // Fetch timeout: four cycles without ack -> HALT with err
        dp.ir_op = 3'b110; dp.mem_ack = 1'b0;
        cyc("to_faddr", B_MA);
        cyc("to_w1", B_RD);
        cyc("to_w2", B_RD);
        cyc("to_w3", B_RD);
        cyc("to_w4", B_RD);
        chk("to_ctl", 32'(ctl), 32'h0);
        chk("to_halted_err", {30'b0, halted, err}, 32'd3);
        chk("to_cnt", 32'(instr_cnt), 32'd3);

        // Ack in the expiry cycle completes normally; then a run of NOPs
        do_reset();
        start = 1'b1;
        cyc("nop_idle", 17'h0); start = 1'b0;
        cyc("nop_faddr", B_MA);
        cyc("nop_w1", B_RD);
        cyc("nop_w2", B_RD);
        cyc("nop_w3", B_RD);
        dp.mem_ack = 1'b1;
        cyc("nop_ack4", B_RD | B_IR | B_PC);
        cyc("nop_decode", B_RT);
        chk("nop_halted_err", {30'b0, halted, err}, 32'd0);
        chk("nop_cnt1", 32'(instr_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc("nopn_faddr", B_MA);
            cyc("nopn_fmem", B_RD | B_IR | B_PC);
            cyc("nopn_decode", B_RT);
            chk("nopn_cnt", 32'(instr_cnt), 32'((i + 2) % 4));
        end

        // HLT retires into HALT; start is ignored there
        dp.ir_op = 3'b111;
        cyc("hlt_faddr", B_MA);
        cyc("hlt_fmem", B_RD | B_IR | B_PC);
        cyc("hlt_decode", B_RT);
        chk("hlt_halted_err", {30'b0, halted, err}, 32'd2);
        chk("hlt_cnt", 32'(instr_cnt), 32'd2);
        start = 1'b1;
        cyc("hlt_start_ctl", 17'h0);
        chk("hlt_start_halted", {31'b0, halted}, 32'd1);
        start = 1'b0;

        // Reset asserted in the middle of an E_MEM read
        do_reset();
        dp.ir_op = 3'b101; dp.ir_ind = 1'b0; dp.mem_ack = 1'b0; start = 1'b1;
        cyc("ar_idle", 17'h0); start = 1'b0;
        cyc("ar_faddr", B_MA);
        dp.mem_ack = 1'b1;
        cyc("ar_fmem", B_RD | B_IR | B_PC);
        dp.mem_ack = 1'b0;
        cyc("ar_decode", 17'h0);
        cyc("ar_eaddr", B_MA | M1_IR);
        @(negedge clk);
        chk("ar_emem", 32'(ctl), 32'(B_RD));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ctl", 32'(ctl), 32'h0);
        chk("ar_state", {29'b0, halted, err, instr_cnt == '0}, 32'd1);
        #5 rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
